// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the two writeback requesters and the register-file write arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  stall;
    logic                  req0_valid;
    logic [4:0]            req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [4:0]            req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  wr_en;
    logic [4:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [7:0]            conflict_cnt;

    modport master (
        output stall, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready, wr_en, wr_addr, wr_data, conflict_cnt
    );

    modport slave (
        input  stall, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready, wr_en, wr_addr, wr_data, conflict_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with registered write port and tie counter.
// Define REGFILE_ARB_RR_EN for round-robin tie-breaking; otherwise requester 1 always wins ties.
module regfile_write_arbiter #(
    parameter int         DATA_WIDTH = 64,
    parameter logic [4:0] ZERO_REG   = 5'd31
) (
    input logic clk,
    input logic reset,
    regfile_write_arbiter_if.slave bus
);
    logic                  prio1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  xfer;
    logic                  tie;
    logic [4:0]            win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    logic                  wr_en_q,   wr_en_d;
    logic [4:0]            wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [7:0]            cnt_q,     cnt_d;

    // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        tie  = !bus.stall && bus.req0_valid && bus.req1_valid;
        if (!reset && !bus.stall) begin
            if (tie) begin
                gnt1 = prio1;
                gnt0 = !prio1;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
        xfer      = gnt0 || gnt1;
        win_addr  = gnt1 ? bus.req1_addr : bus.req0_addr;
        win_data  = gnt1 ? bus.req1_data : bus.req0_data;
        wr_en_d   = xfer && (win_addr != ZERO_REG);
        wr_addr_d = xfer ? win_addr : wr_addr_q;
        wr_data_d = xfer ? win_data : wr_data_q;
        cnt_d     = (tie && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= '0;
            cnt_q     <= 8'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef REGFILE_ARB_RR_EN
    logic ptr_q;

    // Pointer names the requester that wins the next tie: the loser of the last transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (xfer) begin
            ptr_q <= gnt0;
        end
    end

    assign prio1 = ptr_q;
`else
    assign prio1 = 1'b1;
`endif

    assign bus.req0_ready   = gnt0;
    assign bus.req1_ready   = gnt1;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of the write data path.
REQ-002 Parameter ZERO_REG, default 5'd31, hardwired-zero register index whose writes are discarded.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  pipeline hold; when high no grant is issued.
REQ-006 req0_valid / req1_valid  input  1 each  requester has a pending write (req0 = execute writeback, req1 = memory writeback).
REQ-007 req0_addr / req1_addr  input  5 each  destination register index.
REQ-008 req0_data / req1_data  input  DATA_WIDTH each  write data.
REQ-009 req0_ready / req1_ready  output  1 each  combinational grant; a transfer occurs when valid and ready are both high at a clock edge.
REQ-010 wr_en  output  1  registered write enable to the register file's 5:32 write-select decoder.
REQ-011 wr_addr  output  5  registered write register index, drives the decoder select.
REQ-012 wr_data  output  DATA_WIDTH  registered write data.
REQ-013 conflict_cnt  output  8  saturating count of cycles in which both requesters were valid and not stalled.

Function
REQ-014 At most one of req0_ready and req1_ready is high in any cycle.
REQ-015 When stall is high, both ready outputs are low, no transfer occurs, and wr_en is low in the following cycle.
REQ-016 When stall is low and exactly one requester is valid, that requester's ready is high.
REQ-017 When stall is low and both are valid, ready goes to the requester selected by the priority pointer (REQ-025).
REQ-018 When stall is low and neither is valid, both ready outputs are low.
REQ-019 On a transfer, the winning requester's addr and data are captured into wr_addr and wr_data at that edge; latency is exactly 1 cycle.
REQ-020 wr_en is high for exactly the cycle following a transfer whose addr differs from ZERO_REG, and is low in every other cycle.
REQ-021 A transfer to ZERO_REG completes the handshake normally, sets wr_en low, and updates wr_addr and wr_data.
REQ-022 When no transfer occurs, wr_addr and wr_data hold their previous values.
REQ-023 When both requesters target the same address in consecutive grants, both writes are issued in grant order, so the later grant's data prevails in the register file.
REQ-024 conflict_cnt increments by 1 on each cycle in which stall is low and both requesters are valid, and saturates at 8'hFF.
REQ-025 The 1-bit priority pointer is set to the requester that did not win after every transfer, and holds its value otherwise.

Reset
REQ-026 While reset is high: wr_en = 0, wr_addr = 5'd0, wr_data = 0, conflict_cnt = 0, priority pointer = requester 0, and both ready outputs = 0, regardless of other inputs.
REQ-027 Reset asserted mid-operation discards the captured write, so no write-enable pulse is produced for it after reset deasserts.
REQ-028 After reset deasserts, arbitration resumes on the first rising clock edge with the priority pointer at requester 0.

Configuration
REQ-029 The feature is controlled by macro REGFILE_ARB_RR_EN.
REQ-030 With REGFILE_ARB_RR_EN defined, the round-robin pointer behaves as in REQ-025.
REQ-031 Without REGFILE_ARB_RR_EN, the pointer logic is omitted and requester 1 (memory writeback) always wins ties; all other behaviour is unchanged.

Verification
REQ-032 Reset: assert reset mid-transfer with req0_valid=1 and addr=5 -> next cycle wr_en=0, conflict_cnt=0, ready outputs=0; after release, req0 is granted within 1 cycle.
REQ-033 Single requester: req0 with addr=3 and data=0xAB for 1 cycle -> req0_ready=1, then next cycle wr_en=1, wr_addr=3, wr_data=0xAB, then wr_en=0.
REQ-034 Tie, with RR: both valid for 4 cycles with addrs 1/2 -> grants alternate 0,1,0,1, wr_addr sequence is 1,2,1,2, and conflict_cnt=4.
REQ-035 Tie, without RR: same stimulus as REQ-034 -> req1 is granted every cycle and req0_ready stays 0.
REQ-036 Zero register: req1 with addr=31 -> req1_ready=1, next cycle wr_en=0 and wr_addr=31.
REQ-037 Stall and saturation: stall=1 with both valid -> ready outputs=0 and wr_en=0 next cycle; 300 unstalled tie cycles -> conflict_cnt=255.
